// File: rtl/sprite_frame_fetch.sv
// Sprite frame fetch: per-pixel sprite-ROM addressing with animation frame tracking.
// Latency 2 cycles (pixel sampled -> pix_index/pix_hit registered); runs every cycle, no stall.
// Optional 2x pixel scaling when SPRITE_FETCH_SCALE2_EN is defined (box 2*SPR_W x 2*SPR_H).
module sprite_frame_fetch #(
  parameter int          SPR_W           = 40,
  parameter int          SPR_H           = 40,
  parameter int          NUM_FRAMES      = 4,
  parameter int          FRAME_HOLD      = 6,
  parameter int          ADDR_W          = 13,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'd0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_start_i,
  input  logic              run_en_i,
  input  logic              facing_left_i,
  input  logic [9:0]        sprite_x_i,
  input  logic [9:0]        sprite_y_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [3:0]        rom_data_i,
  output logic [3:0]        pix_index_o,
  output logic              pix_hit_o,
  output logic [1:0]        frame_num_o
);

`ifdef SPRITE_FETCH_SCALE2_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam logic [10:0] BOX_W    = 11'(SPR_W << SCALE_SH);
  localparam logic [10:0] BOX_H    = 11'(SPR_H << SCALE_SH);
  localparam logic [31:0] FRAME_SZ = 32'(SPR_W * SPR_H);
  localparam logic [31:0] ROW_SZ   = 32'(SPR_W);
  localparam int          HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [1:0]        FRAME_LAST = 2'(NUM_FRAMES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        frame_q, frame_d;
  logic              facing_q;

  logic [10:0]       dx, dy, x_hi, y_hi, tex_x, tex_y, xo;
  logic              in_box;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              in_box_d1_q, in_box_d2_q;
  logic [3:0]        pix_index_q;
  logic              pix_hit_q, pix_hit_d;

  // Offsets, box test (11-bit so sprites past the screen edge never wrap), mirror and address.
  always_comb begin
    dx     = {1'b0, draw_x_i} - {1'b0, sprite_x_i};
    dy     = {1'b0, draw_y_i} - {1'b0, sprite_y_i};
    x_hi   = {1'b0, sprite_x_i} + BOX_W;
    y_hi   = {1'b0, sprite_y_i} + BOX_H;
    in_box = (draw_x_i >= sprite_x_i) && ({1'b0, draw_x_i} < x_hi) &&
             (draw_y_i >= sprite_y_i) && ({1'b0, draw_y_i} < y_hi);
    tex_x  = dx >> SCALE_SH;
    tex_y  = dy >> SCALE_SH;
    xo     = facing_q ? (11'(SPR_W - 1) - tex_x) : tex_x;
    rom_addr_d = rom_addr_q;
    if (in_box) begin
      rom_addr_d = ADDR_W'(32'(frame_q) * FRAME_SZ + 32'(tex_y) * ROW_SZ + 32'(xo));
    end
    pix_hit_d = in_box_d2_q && (rom_data_i != TRANSPARENT_IDX);
  end

  // Two-stage pixel pipeline: address/box, box delay aligned with ROM, then output register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rom_addr_q  <= '0;
      in_box_d1_q <= 1'b0;
      in_box_d2_q <= 1'b0;
      pix_index_q <= 4'd0;
      pix_hit_q   <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      in_box_d1_q <= in_box;
      in_box_d2_q <= in_box_d1_q;
      pix_index_q <= rom_data_i;
      pix_hit_q   <= pix_hit_d;
    end
  end

  // Facing is latched only at vertical blank so the mirror never changes mid-frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      facing_q <= 1'b0;
    end else if (frame_start_i) begin
      facing_q <= facing_left_i;
    end
  end

  // Animation state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  // Animation next-state: advances only on frame_start pulses.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    if (frame_start_i) begin
      case (state_q)
        IDLE: begin
          hold_d  = '0;
          frame_d = 2'd0;
          if (run_en_i) state_d = RUN;
        end
        RUN: begin
          if (!run_en_i) begin
            state_d = IDLE;
            hold_d  = '0;
            frame_d = 2'd0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            frame_d = (frame_q == FRAME_LAST) ? 2'd0 : frame_q + 2'd1;
          end else begin
            hold_d  = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
          frame_d = 2'd0;
        end
      endcase
    end
  end

  // Animation outputs.
  always_comb begin
    frame_num_o = frame_q;
  end

  assign rom_addr_o  = rom_addr_q;
  assign pix_index_o = pix_index_q;
  assign pix_hit_o   = pix_hit_q;

endmodule

// File: tb/tb_sprite_frame_fetch.sv
// Testbench for sprite_frame_fetch: directed vector table plus multi-cycle sequences.
// Models the synchronous sprite ROM; expected values are hand-computed constants.
// Build with SPRITE_FETCH_SCALE2_EN to exercise the 2x scaled variant.
module tb_sprite_frame_fetch;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        frame_start_i = 1'b0;
  logic        run_en_i = 1'b0;
  logic        facing_left_i = 1'b0;
  logic [9:0]  sprite_x_i = '0, sprite_y_i = '0, draw_x_i = '0, draw_y_i = '0;
  logic [12:0] rom_addr_o;
  logic [3:0]  rom_data_i = '0;
  logic [3:0]  pix_index_o;
  logic        pix_hit_o;
  logic [1:0]  frame_num_o;

  int tests = 0;
  int fails = 0;

  logic [3:0] rom_mem [0:8191];

`ifdef SPRITE_FETCH_SCALE2_EN
  localparam int LAT_OFF  = 42;   // (105,52) vs (100,50): tex (2,1) -> 40+2
  localparam int MIR_ADDR = 77;   // 40 + (39-2)
`else
  localparam int LAT_OFF  = 85;   // 2*40+5
  localparam int MIR_ADDR = 114;  // 2*40+34
`endif

  sprite_frame_fetch dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .frame_start_i (frame_start_i),
    .run_en_i      (run_en_i),
    .facing_left_i (facing_left_i),
    .sprite_x_i    (sprite_x_i),
    .sprite_y_i    (sprite_y_i),
    .draw_x_i      (draw_x_i),
    .draw_y_i      (draw_y_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .pix_index_o   (pix_index_o),
    .pix_hit_o     (pix_hit_o),
    .frame_num_o   (frame_num_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

  typedef struct {
    logic [9:0] sx, sy, px, py;
    int         exp_addr;
    logic       exp_hit;
    logic       chk_idx;
    logic [3:0] exp_idx;
  } vec_t;

  function automatic vec_t mk(int sx, int sy, int px, int py, int a, int h, int ci, int idx);
    vec_t v;
    v.sx = 10'(sx); v.sy = 10'(sy); v.px = 10'(px); v.py = 10'(py);
    v.exp_addr = a; v.exp_hit = 1'(h); v.chk_idx = 1'(ci); v.exp_idx = 4'(idx);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold one pixel for three edges: address after the first, pixel outputs after the third.
  task automatic run_pix(input logic [9:0] sx, input logic [9:0] sy, input logic [9:0] px,
                         input logic [9:0] py, output logic [12:0] a, output logic h,
                         output logic [3:0] idx);
    @(negedge clk);
    sprite_x_i = sx; sprite_y_i = sy; draw_x_i = px; draw_y_i = py;
    @(posedge clk); #1;
    a = rom_addr_o;
    repeat (2) @(posedge clk);
    #1;
    h = pix_hit_o; idx = pix_index_o;
  endtask

  task automatic pulse();
    repeat (2) @(posedge clk);
    @(negedge clk);
    frame_start_i = 1'b1;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
  endtask

  vec_t        vecs[12];
  logic [12:0] a;
  logic        h;
  logic [3:0]  idx;
  logic        e1, e2, ex;

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'((i % 15) + 1);
    rom_mem[LAT_OFF]  = 4'd7;
    rom_mem[MIR_ADDR] = 4'd0;
    rom_mem[200]      = 4'd0;

`ifdef SPRITE_FETCH_SCALE2_EN
    vecs[0]  = mk(0, 0, 3, 5, 81, 1, 1, 7);
    vecs[1]  = mk(0, 0, 79, 0, 39, 1, 1, 10);
    vecs[2]  = mk(0, 0, 80, 0, 39, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 80, 39, 0, 0, 0);
    vecs[4]  = mk(0, 0, 79, 79, 1599, 1, 1, 10);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 1, 1);
    vecs[6]  = mk(100, 50, 179, 50, 39, 1, 1, 10);
    vecs[7]  = mk(100, 50, 180, 50, 39, 0, 0, 0);
    vecs[8]  = mk(630, 10, 0, 10, 39, 0, 0, 0);
    vecs[9]  = mk(630, 10, 639, 10, 4, 1, 1, 5);
    vecs[10] = mk(630, 470, 630, 479, 160, 1, 1, 11);
    vecs[11] = mk(630, 470, 630, 0, 160, 0, 0, 0);
`else
    vecs[0]  = mk(100, 50, 105, 52, 85, 1, 1, 7);
    vecs[1]  = mk(100, 50, 100, 50, 0, 1, 1, 1);
    vecs[2]  = mk(100, 50, 139, 89, 1599, 1, 1, 10);
    vecs[3]  = mk(100, 50, 140, 50, 1599, 0, 0, 0);
    vecs[4]  = mk(100, 50, 99, 50, 1599, 0, 0, 0);
    vecs[5]  = mk(100, 50, 100, 90, 1599, 0, 0, 0);
    vecs[6]  = mk(100, 50, 120, 70, 820, 1, 1, 11);
    vecs[7]  = mk(100, 50, 100, 55, 200, 0, 1, 0);
    vecs[8]  = mk(630, 10, 0, 10, 200, 0, 0, 0);
    vecs[9]  = mk(630, 10, 639, 10, 9, 1, 1, 10);
    vecs[10] = mk(630, 470, 630, 479, 360, 1, 1, 1);
    vecs[11] = mk(630, 470, 630, 0, 360, 0, 0, 0);
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset rom_addr", 32'(rom_addr_o), 0);
    check("reset pix_index", 32'(pix_index_o), 0);
    check("reset pix_hit", 32'(pix_hit_o), 0);
    check("reset frame_num", 32'(frame_num_o), 0);
    @(negedge clk);
    reset_i = 1'b0;

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      run_pix(vecs[i].sx, vecs[i].sy, vecs[i].px, vecs[i].py, a, h, idx);
      check($sformatf("vec%0d rom_addr", i), 32'(a), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d pix_hit", i), 32'(h), 32'(vecs[i].exp_hit));
      if (vecs[i].chk_idx) check($sformatf("vec%0d pix_index", i), 32'(idx), 32'(vecs[i].exp_idx));
    end

    // Latency: single in-box pixel between out-of-box pixels.
    @(negedge clk);
    sprite_x_i = 10'd100; sprite_y_i = 10'd50; draw_x_i = 10'd0; draw_y_i = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    draw_x_i = 10'd105; draw_y_i = 10'd52;
    @(posedge clk); #1;
    check("lat N rom_addr", 32'(rom_addr_o), LAT_OFF);
    check("lat N pix_hit", 32'(pix_hit_o), 0);
    @(negedge clk);
    draw_x_i = 10'd0; draw_y_i = 10'd0;
    @(posedge clk); #1;
    check("lat N+1 pix_hit", 32'(pix_hit_o), 0);
    @(posedge clk); #1;
    check("lat N+2 pix_hit", 32'(pix_hit_o), 1);
    check("lat N+2 pix_index", 32'(pix_index_o), 7);
    @(posedge clk); #1;
    check("lat N+3 pix_hit", 32'(pix_hit_o), 0);
    check("lat hold rom_addr", 32'(rom_addr_o), LAT_OFF);

    // Right-edge sweep: no wrap into DrawX 0..29.
    @(negedge clk);
    sprite_x_i = 10'd630; sprite_y_i = 10'd10; draw_x_i = 10'd0; draw_y_i = 10'd12;
    repeat (2) @(posedge clk);
    e1 = 1'b0; e2 = 1'b0;
    for (int x = 0; x < 642; x++) begin
      @(negedge clk);
      draw_x_i = (x < 640) ? 10'(x) : 10'd0;
      ex = (x >= 630 && x <= 639);
      @(posedge clk); #1;
      check($sformatf("sweep x=%0d pix_hit", x - 2), 32'(pix_hit_o), 32'(e2));
      e2 = e1; e1 = ex;
    end

    // Mirror: facing latched on frame_start only.
    @(negedge clk);
    sprite_x_i = 10'd100; sprite_y_i = 10'd50; draw_x_i = 10'd0; draw_y_i = 10'd0;
    facing_left_i = 1'b1;
    pulse();
    run_pix(10'd100, 10'd50, 10'd105, 10'd52, a, h, idx);
    check("mirror rom_addr", 32'(a), MIR_ADDR);
    check("mirror transparent pix_hit", 32'(h), 0);
    check("mirror pix_index", 32'(idx), 0);
    facing_left_i = 1'b0;
    run_pix(10'd100, 10'd0, 10'd105, 10'd2, a, h, idx);
    check("facing unlatched rom_addr", 32'(a), MIR_ADDR);
    check("facing unlatched frame_num", 32'(frame_num_o), 0);

    // Animation: 25 pulses, with a pulse coinciding with an in-box pixel at the 0->1 step.
    @(negedge clk);
    sprite_x_i = 10'd100; sprite_y_i = 10'd50; draw_x_i = 10'd0; draw_y_i = 10'd0;
    run_en_i = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 7) begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        frame_start_i = 1'b1; draw_x_i = 10'd105; draw_y_i = 10'd52;
        @(posedge clk); #1;
        frame_start_i = 1'b0;
        check("coincide pre-update rom_addr", 32'(rom_addr_o), LAT_OFF);
        @(posedge clk); #1;
        check("coincide post-update rom_addr", 32'(rom_addr_o), 1600 + LAT_OFF);
        @(negedge clk);
        draw_x_i = 10'd0; draw_y_i = 10'd0;
      end else begin
        pulse();
      end
      check($sformatf("anim pulse %0d frame_num", k), 32'(frame_num_o), 32'(((k - 1) / 6) % 4));
    end
    run_en_i = 1'b0;
    pulse();
    check("run_en drop frame_num", 32'(frame_num_o), 0);

    // Back in IDLE: next pulse is IDLE->RUN, so frame 0 lasts six pulses again.
    run_en_i = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      pulse();
      check($sformatf("anim2 pulse %0d frame_num", k), 32'(frame_num_o), 32'(((k - 1) / 6) % 4));
    end

    // Reset mid-RUN at frame 2 with an in-box pixel in flight.
    run_pix(10'd100, 10'd50, 10'd105, 10'd52, a, h, idx);
    check("frame2 rom_addr", 32'(a), 3200 + LAT_OFF);
    check("frame2 pix_hit", 32'(h), 1);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("midrun reset frame_num", 32'(frame_num_o), 0);
    check("midrun reset pix_hit", 32'(pix_hit_o), 0);
    check("midrun reset rom_addr", 32'(rom_addr_o), 0);
    check("midrun reset pix_index", 32'(pix_index_o), 0);
    @(negedge clk);
    reset_i = 1'b0; draw_x_i = 10'd0; draw_y_i = 10'd0;
    pulse();
    check("post-reset pulse1 frame_num", 32'(frame_num_o), 0);
    pulse();
    check("post-reset pulse2 frame_num", 32'(frame_num_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_frame_fetch.md
Name: sprite_frame_fetch

Overview:
- Pixel-pipeline stage directly upstream of the per-character palette lookup (4-bit index -> 12-bit RGB).
- Tracks animation state for one character, e.g. the run cycle. For each VGA pixel it computes the sprite-ROM address, issues it to a synchronous ROM and returns the 4-bit palette index with a hit flag.
- The palette block consumes the returned index. The compositor uses pix_hit to choose between the sprite and the background.

Parameters:
- SPR_W, 40, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_HOLD, 6, video frames each animation frame is displayed
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPR_W*SPR_H
- TRANSPARENT_IDX, 0, palette index treated as see-through

Ports:
- Clk, in, 1, pixel clock
- Reset, in, 1, synchronous, active-high
- frame_start, in, 1, one-cycle pulse at start of vertical blank
- run_en, in, 1, animate when high
- facing_left, in, 1, horizontal mirror request
- sprite_x, in, 10, sprite top-left X, screen pixels
- sprite_y, in, 10, sprite top-left Y, screen pixels
- DrawX, in, 10, current pixel X
- DrawY, in, 10, current pixel Y
- rom_addr, out, ADDR_W, address to sprite ROM
- rom_data, in, 4, ROM output, valid one cycle after rom_addr
- pix_index, out, 4, palette index for the palette stage
- pix_hit, out, 1, pixel inside sprite and not transparent
- frame_num, out, 2, current animation frame

Behaviour:
- Reset, synchronous: rom_addr=0, pix_index=0, pix_hit=0, frame_num=0, hold counter=0, state=IDLE, latched facing=0. Reset has priority over all events and over in-flight pipeline data.
- Offsets:
  - dx = DrawX - sprite_x, dy = DrawY - sprite_y, computed with 11-bit unsigned math.
  - in_box = DrawX >= sprite_x && {1'b0,DrawX} < sprite_x+SPR_W, and the same test in Y.
  - Sprites extending past 639/479 must not wrap.
- Mirror: xo = facing_l ? SPR_W-1-dx : dx, where facing_l is facing_left latched on frame_start only. This prevents tearing mid-frame.
- Address: frame_num*SPR_W*SPR_H + dy*SPR_W + xo, truncated to ADDR_W.
- Pipeline, latency 2:
  - Edge N: DrawX/DrawY are sampled; rom_addr and in_box_d1 are registered.
  - Edge N+1: in_box_d2 is registered; rom_data becomes valid.
  - Edge N+2: pix_index=rom_data and pix_hit=in_box_d2 && (rom_data!=TRANSPARENT_IDX) are registered.
  - Outside the box, rom_addr holds its last value and pix_hit=0. pix_index is still loaded from rom_data and is don't-care.
  - The pipeline runs every cycle and has no stall.
- Animation FSM, updated only on cycles where frame_start=1:
  - IDLE, run_en=0: frame_num=0, hold=0, stay IDLE.
  - IDLE, run_en=1: go to RUN, frame_num=0, hold=0.
  - RUN, run_en=0: go to IDLE, frame_num=0, hold=0, taking effect this same pulse.
  - RUN, run_en=1, hold<FRAME_HOLD-1: hold++.
  - RUN, run_en=1, hold==FRAME_HOLD-1: hold=0, frame_num = (frame_num==NUM_FRAMES-1) ? 0 : frame_num+1.
- run_en and facing_left changes between frame_start pulses have no effect until the next pulse.
- A frame_start pulse coinciding with an in-box pixel: the address for that pixel uses the pre-update frame_num and facing.

Optional Feature:
- Macro SPRITE_FETCH_SCALE2_EN.
- Defined: the on-screen box becomes 2*SPR_W x 2*SPR_H; dx>>1 and dy>>1 are used before mirroring and addressing, so each texel covers 2x2 pixels. Mirror uses SPR_W-1-(dx>>1).
- Undefined: 1:1 mapping as above. Latency is 2 in both builds.

Test Plan:
- Reset asserted mid-RUN with frame_num=2 -> next edge: frame_num=0, pix_hit=0, rom_addr=0. Two frame_start pulses with run_en=1 then leave frame_num=0 (IDLE->RUN, then hold=1).
- sprite=(100,50), facing=0, frame 0, DrawX=105, DrawY=52 -> rom_addr=85 one edge later. With ROM returning 7, two edges after sampling: pix_index=7, pix_hit=1.
- Same pixel with facing_left latched 1 -> rom_addr=2*40+34=114. ROM returning 0 -> pix_hit=0.
- FRAME_HOLD=6, run_en=1, 25 frame_start pulses -> frame_num sequence 0 (x6 pulses, counting IDLE->RUN), 1 (x6), 2, 3, then wraps to 0. Dropping run_en before pulse 26 -> frame_num=0, IDLE.
- sprite_x=630, DrawX sweep 0..639 -> pix_hit only for DrawX 630..639, never at DrawX 0..29.
- SCALE2 build: sprite=(0,0), DrawX=3, DrawY=5 -> rom_addr=2*40+1=81. DrawX=79 -> hit region. DrawX=80 -> pix_hit=0.
